// File: rtl/mario_anim_addr_gen.sv
// Mario sprite address/frame-select stage: maps the scan position onto a 21x21 ROM address,
// mirrors it for left-facing motion, and runs the per-frame walk/jump pose sequencer.
module mario_anim_addr_gen #(
  parameter int SPR_W       = 21,
  parameter int SPR_H       = 21,
  parameter int ANIM_PERIOD = 6,
  parameter int ADDR_W      = 9
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        mario_x,
  input  logic [9:0]        mario_y,
  input  logic              walking,
  input  logic              jumping,
  input  logic              facing_left,
  output logic [ADDR_W-1:0] read_address,
  output logic [2:0]        sprite_sel,
  output logic              in_sprite
);

  localparam int CNT_W = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ANIM_PERIOD - 1);
  localparam logic [10:0] SPR_W11 = 11'(SPR_W);
  localparam logic [10:0] SPR_H11 = 11'(SPR_H);

  typedef enum logic [2:0] {
    STAND = 3'd0,
    WALK1 = 3'd1,
    WALK2 = 3'd2,
    WALK3 = 3'd3,
    JUMP  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              frame_clk_d;
  logic              frame_tick;
  logic [9:0]        pos_x, pos_y;
  logic              face_l;

  logic [10:0]       x_p0, y_p0, px_p0, py_p0, dx_p0, dy_p0, col_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              hit_p0;
  logic [ADDR_W-1:0] read_address_p1;
  logic              in_sprite_p1;

  assign frame_tick = frame_clk & ~frame_clk_d;

  // Pose sequencer: only advances on a frame tick; jumping outranks walking.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (frame_tick) begin
      if (jumping) begin
        state_nxt = JUMP;
        cnt_nxt   = '0;
      end else if (walking && (state == STAND || state == JUMP)) begin
        state_nxt = WALK1;
        cnt_nxt   = '0;
      end else if (walking) begin
        if (cnt == CNT_MAX) begin
          cnt_nxt = '0;
          case (state)
            WALK1:   state_nxt = WALK2;
            WALK2:   state_nxt = WALK3;
            default: state_nxt = WALK1;
          endcase
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else begin
        state_nxt = STAND;
        cnt_nxt   = '0;
      end
    end
  end

  // Position and facing are frozen for the whole frame so the sprite never tears.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= STAND;
      cnt         <= '0;
      frame_clk_d <= 1'b1;
      pos_x       <= '0;
      pos_y       <= '0;
      face_l      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      frame_clk_d <= frame_clk;
      if (frame_tick) begin
        pos_x  <= mario_x;
        pos_y  <= mario_y;
        face_l <= facing_left;
      end
    end
  end

  // Stage p0: 11-bit box test and address so pos_x+SPR_W cannot wrap at the screen edge.
  always_comb begin
    x_p0   = {1'b0, DrawX};
    y_p0   = {1'b0, DrawY};
    px_p0  = {1'b0, pos_x};
    py_p0  = {1'b0, pos_y};
    hit_p0 = (x_p0 >= px_p0) && (x_p0 < px_p0 + SPR_W11) &&
             (y_p0 >= py_p0) && (y_p0 < py_p0 + SPR_H11);
    dx_p0  = x_p0 - px_p0;
    dy_p0  = y_p0 - py_p0;
    col_p0 = face_l ? (SPR_W11 - 11'd1 - dx_p0) : dx_p0;
    addr_p0 = ADDR_W'(dy_p0 * SPR_W11 + col_p0);
  end

  // Stage p1: registered outputs, one pixel behind DrawX/DrawY.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address_p1 <= '0;
      in_sprite_p1    <= 1'b0;
    end else begin
      read_address_p1 <= hit_p0 ? addr_p0 : '0;
      in_sprite_p1    <= hit_p0;
    end
  end

  assign read_address = read_address_p1;
  assign in_sprite    = in_sprite_p1;
  assign sprite_sel   = state;

endmodule
